pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_ras.sv | 76 +++++++
 rtl/pc_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter generator.
package pc_pkg;

  // Source of the next program counter value, listed from lowest to highest
  // priority. The synchronous clear is handled by the state register itself.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_RAS,
    SEL_TRAP
  } pc_sel_e;

  // One-hot style command bundle for the return-address stack. At most one
  // field is set in any cycle; replace wins if the producer ever sets more.
  typedef struct packed {
    logic push;
    logic pop;
    logic replace;
  } ras_cmd_t;

  // Default reset and trap vectors; narrower instances truncate them.
  localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC_DEFAULT  = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry, so the stack always holds the most recent RAS_DEPTH returns.
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  ras_cmd_t          cmd_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ptr_q addresses the next free slot; the top of stack sits just below it.
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  wr_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];

  assign top_idx = ptr_q - PTR_W'(1);
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_o   = mem_q[top_idx];

  // Next pointer/count and the storage write port for this cycle's command.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (cmd_i.replace) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (cmd_i.push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (cmd_i.pop && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; clear empties the stack.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (clr_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; written by push or replace.
  always_ff @(posedge clk_i) begin
    // NOTE: the entries carry no reset; an emptied stack never reads them
    // back before a push overwrites them, and leaving them out lets the
    // array map onto plain storage.
    if (!clr_i && wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, branch/jump/trap redirects and
// a return-address stack for call/return prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(PC_RESET_VEC_DEFAULT),
  parameter logic [31:0]       TRAP_VEC   = PC_TRAP_VEC_DEFAULT,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Stall,
  input  logic              BrTaken,
  input  logic [ADDR_W-1:0] BrTarget,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              Call,
  input  logic              Ret,
  input  logic              Trap,
  output logic [ADDR_W-1:0] currentAddress,
  output logic              RasEmpty,
  output logic              RasFull,
  output logic              RasUnderflow
);

  localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] TRAP_TARGET = ADDR_W'(TRAP_VEC) & ALIGN_MASK;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              underflow_q, underflow_d;
  pc_sel_e           sel;
  ras_cmd_t          ras_cmd;

  // Return address of the instruction currently being fetched.
  assign ret_addr = pc_q + STEP;

  // Priority decode: pick the next-PC source and the stack operation.
  always_comb begin
    sel         = SEL_HOLD;
    ras_cmd     = '0;
    underflow_d = 1'b0;
    if (Clr) begin
      sel = SEL_HOLD;
    end else if (Trap) begin
      sel = SEL_TRAP;
    end else if (Ret) begin
      if (!ras_empty) begin
        sel = SEL_RAS;
        // A call paired with a return swaps the top entry in place.
        if (Jump && Call) ras_cmd.replace = 1'b1;
        else              ras_cmd.pop     = 1'b1;
      end else begin
        sel         = SEL_JUMP;
        underflow_d = 1'b1;
      end
    end else if (Jump) begin
      sel          = SEL_JUMP;
      ras_cmd.push = Call;
    end else if (BrTaken) begin
      sel = SEL_BRANCH;
    end else if (!Stall) begin
      sel = SEL_INC;
    end
  end

  // Next-PC mux; every redirect target is forced to instruction alignment.
  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_INC:    pc_d = pc_q + STEP;
      SEL_BRANCH: pc_d = BrTarget & ALIGN_MASK;
      SEL_JUMP:   pc_d = JumpTarget & ALIGN_MASK;
      SEL_RAS:    pc_d = ras_top & ALIGN_MASK;
      SEL_TRAP:   pc_d = TRAP_TARGET;
      default:    pc_d = pc_q;
    endcase
  end

  // PC and underflow-pulse registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      pc_q        <= RESET_VEC;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      underflow_q <= underflow_d;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (Clk),
    .clr_i   (Clr),
    .cmd_i   (ras_cmd),
    .data_i  (ret_addr),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  assign currentAddress = pc_q;
  assign RasEmpty       = ras_empty;
  assign RasFull        = ras_full;
  assign RasUnderflow   = underflow_q;

endmodule
